// File: rtl/pc_gen.sv
// Fetch PC generator: boot/run sequencing, redirect priority, and a direct-mapped
// BTB looked up on the registered PC.
module pc_gen #(
  parameter int unsigned          XLEN      = 32,
  parameter logic [XLEN-1:0]      RESET_VEC = 32'h0000_0000,
  parameter int unsigned          IALIGN    = 4,
  parameter int unsigned          BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_addr_i,
  input  logic            br_ctrl_i,
  input  logic [XLEN-1:0] br_addr_i,
  input  logic            stall_i,
  input  logic            fetch_ready_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o,
  input  logic            btb_upd_i,
  input  logic [XLEN-1:0] btb_upd_pc_i,
  input  logic [XLEN-1:0] btb_upd_tgt_i,
  input  logic            btb_upd_taken_i
);

  localparam int unsigned OFF  = $clog2(IALIGN);
  localparam int unsigned IDXW = $clog2(BTB_DEPTH);
  localparam int unsigned TAGW = XLEN - OFF - IDXW;
  localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << OFF;

  typedef enum logic {BOOT, RUN} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            accept;

  logic            valid_q [BTB_DEPTH];
  logic [TAGW-1:0] tag_q   [BTB_DEPTH];
  logic [XLEN-1:0] tgt_q   [BTB_DEPTH];

  logic [IDXW-1:0] lk_idx, upd_idx;
  logic [TAGW-1:0] lk_tag, upd_tag;
  logic            unused_upd_lowbits;

  assign lk_idx  = pc_q[OFF +: IDXW];
  assign lk_tag  = pc_q[XLEN-1 -: TAGW];
  assign upd_idx = btb_upd_pc_i[OFF +: IDXW];
  assign upd_tag = btb_upd_pc_i[XLEN-1 -: TAGW];
  assign unused_upd_lowbits = ^btb_upd_pc_i[OFF-1:0];

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Outputs
  always_comb begin
    fetch_valid_o = (state_q == RUN);
    pred_taken_o  = (state_q == RUN) && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pc_o          = pc_q;
  end

  assign accept = fetch_valid_o && fetch_ready_i && !stall_i;

  always_comb begin
    pc_d = pc_q;
    if (flush_i)                    pc_d = flush_addr_i & ALIGN_MASK;
    else if (br_ctrl_i)             pc_d = br_addr_i & ALIGN_MASK;
    else if (accept && pred_taken_o) pc_d = tgt_q[lk_idx];
    else if (accept)                pc_d = pc_q + XLEN'(IALIGN);
  end

  // Not-taken updates only drop an entry that really belongs to this branch,
  // so an aliasing branch cannot evict another's prediction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < BTB_DEPTH; i++) valid_q[i] <= 1'b0;
    end else if (btb_upd_i) begin
      if (btb_upd_taken_i)
        valid_q[upd_idx] <= 1'b1;
      else if (valid_q[upd_idx] && tag_q[upd_idx] == upd_tag)
        valid_q[upd_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (btb_upd_i && btb_upd_taken_i) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= btb_upd_tgt_i & ALIGN_MASK;
    end
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, address width.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, first fetch address.
REQ-003 SHALL have parameter IALIGN, default 4, instruction alignment in bytes (2 or 4).
REQ-004 SHALL have parameter BTB_DEPTH, default 16, BTB entries (power of two, >=2).
REQ-005 clk  in  1  clock, rising edge.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 flush_i  in  1  trap/exception redirect.
REQ-008 flush_addr_i  in  XLEN  trap target.
REQ-009 br_ctrl_i  in  1  branch/jump redirect (mispredict correction).
REQ-010 br_addr_i  in  XLEN  branch target.
REQ-011 stall_i  in  1  hazard stall, hold PC.
REQ-012 fetch_ready_i  in  1  fetch stage accepts pc_o.
REQ-013 fetch_valid_o  out  1  pc_o is a valid fetch request.
REQ-014 pc_o  out  XLEN  current fetch PC, registered.
REQ-015 pred_taken_o  out  1  BTB hit on pc_o, combinational.
REQ-016 btb_upd_i  in  1  BTB update strobe.
REQ-017 btb_upd_pc_i  in  XLEN  PC of resolved branch.
REQ-018 btb_upd_tgt_i  in  XLEN  resolved target.
REQ-019 btb_upd_taken_i  in  1  branch resolved taken.

Function
REQ-020 FSM SHALL have states BOOT and RUN; reset enters BOOT; BOOT->RUN unconditionally on the next clock; RUN is held until reset.
REQ-021 fetch_valid_o SHALL be 0 in BOOT and 1 in RUN.
REQ-022 Accept SHALL mean fetch_valid_o && fetch_ready_i && !stall_i.
REQ-023 Next-PC priority SHALL be: flush_i -> flush_addr_i; else br_ctrl_i -> br_addr_i; else accept && pred_taken_o -> BTB target; else accept -> pc_o+IALIGN; else hold pc_o.
REQ-024 flush_i and br_ctrl_i SHALL load pc_o on the next edge regardless of stall_i, fetch_ready_i or FSM state; flush_i wins when both are asserted.
REQ-025 Redirect and BTB target addresses SHALL have low log2(IALIGN) bits forced to zero before loading pc_o.
REQ-026 pc_o+IALIGN SHALL wrap modulo 2^XLEN (all-ones-aligned to 0), no flag.
REQ-027 BTB index SHALL be pc[log2(IALIGN)+log2(BTB_DEPTH)-1 : log2(IALIGN)]; tag SHALL be all bits above the index; each entry has valid, tag, target.
REQ-028 pred_taken_o SHALL be 1 iff the indexed entry is valid, its tag matches pc_o and fetch_valid_o=1.
REQ-029 On btb_upd_i with taken=1, the indexed entry SHALL be written (valid=1, tag, target) at the next edge.
REQ-030 On btb_upd_i with taken=0, the entry SHALL be invalidated only if valid and tag-matching; otherwise unchanged.
REQ-031 Update and lookup at the same index in the same cycle SHALL see pre-update contents; the new contents are visible the following cycle.
REQ-032 Held pc_o SHALL keep pred_taken_o stable unless the BTB entry changes.

Reset
REQ-033 rstn low SHALL asynchronously set pc_o=RESET_VEC, FSM=BOOT, fetch_valid_o=0, all BTB valid bits=0.
REQ-034 Reset asserted mid-operation SHALL discard pending redirects and updates; first accepted PC after release is RESET_VEC.

Verification
REQ-035 Reset release, fetch_ready_i=1: fetch_valid_o 0 for one cycle, then pc_o 0x0, 0x4, 0x8 on consecutive accepts.
REQ-036 stall_i=1 at pc_o=0x10 for 3 cycles with br_ctrl_i=1, br_addr_i=0x103 in cycle 2: pc_o=0x100 next edge, then held until stall_i=0.
REQ-037 flush_i=1 (0x200) and br_ctrl_i=1 (0x300) same cycle: pc_o=0x200.
REQ-038 BTB update pc=0x40, tgt=0x80, taken=1; later fetch reaches 0x40: pred_taken_o=1, next pc_o=0x80; update taken=0 for 0x40, revisit: pc_o 0x40 -> 0x44.
REQ-039 Aliasing: entry for 0x40 valid, update taken=0 for 0x440 (same index, other tag): 0x40 entry retained.
REQ-040 pc_o=0xFFFF_FFFC accepted: next pc_o=0x0000_0000.
